// File: rtl/packet_switch_pkg.sv
// Shared definitions for the packet switch pipe receive buffer.
// Holds the credit threshold helper and the parameter legality check that
// the receive buffer applies at elaboration.
package packet_switch_pkg;

  // Highest post-update occupancy at which the credit may still be granted.
  // It leaves N+1 free entries for the beats already in flight.
  function automatic int pipe_rx_credit_thresh(input int depth, input int n);
    return depth - n - 1;
  endfunction

  // Legal sizing: enough headroom for the in-flight beats plus one, and a
  // power-of-two depth so that the pointers wrap naturally.
  function automatic bit pipe_rx_params_ok(input int depth, input int n);
    return (n >= 1) && (depth >= n + 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/packet_switch_pipe_rx_buf_mem.sv
// Storage array for the receive buffer: one synchronous write port and one
// asynchronous (show-ahead) read port. There is no reset, because contents
// are only meaningful while the owner's occupancy count covers them.
// Ports:
//   clk      clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data, combinational from i_raddr
module packet_switch_pipe_rx_buf_mem #(
  parameter int W     = 64,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/packet_switch_pipe_rx_buf.sv
// Latency-absorbing receive buffer at the far end of a fixed N-cycle pipe.
// It issues a registered credit (up_ready) to the sender and accepts every
// beat that arrives N cycles later, then presents the beats downstream on a
// valid/ready interface.
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   in_valid   beat arriving from the delayed pipe (cannot be stalled)
//   in_data    arriving payload
//   up_ready   registered credit to the sender
//   out_valid  buffer non-empty
//   out_data   head payload, show-ahead
//   out_ready  downstream accept
//   occupancy  current entry count
//   overflow   sticky: a beat arrived while the buffer was full
module packet_switch_pipe_rx_buf
  import packet_switch_pkg::*;
#(
  parameter int W     = 64,
  parameter int N     = 2,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [W-1:0]               in_data,
  output logic                       up_ready,
  output logic                       out_valid,
  output logic [W-1:0]               out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(pipe_rx_credit_thresh(DEPTH, N));

  if (!pipe_rx_params_ok(DEPTH, N)) begin : g_bad_params
    $error("packet_switch_pipe_rx_buf: need N >= 1, DEPTH >= N+2, DEPTH power of two");
  end

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_up_ready;
  logic          r_overflow;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_next;

  // Fullness is judged on the pre-pop count, so a beat arriving at full is
  // dropped even if the head leaves in the same cycle.
  assign w_full = (r_count == DEPTH_C);
  assign w_push = in_valid && !w_full;
  assign w_pop  = (r_count != '0) && out_ready;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_next = r_count - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_up_ready <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count    <= w_count_next;
      // Credit looks at the post-update count so it already accounts for
      // this cycle's push and pop.
      r_up_ready <= (w_count_next <= THRESH_C);
      if (in_valid && w_full) r_overflow <= 1'b1;
    end
  end

  packet_switch_pipe_rx_buf_mem #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (out_data)
  );

  assign up_ready  = r_up_ready;
  assign out_valid = (r_count != '0);
  assign occupancy = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_packet_switch_pipe_rx_buf.sv
module tb_packet_switch_pipe_rx_buf;

  localparam int W     = 64;
  localparam int N     = 2;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int THR   = DEPTH - N - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          up_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [CW-1:0] occupancy;
  logic          overflow;

  packet_switch_pipe_rx_buf #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .up_ready  (up_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a queue of stored beats, the credit and the sticky flag.
  logic [W-1:0] m_q[$];
  logic         m_rdy;
  logic         m_ovf;

  task automatic model_reset();
    m_q.delete();
    m_rdy = 1'b0;
    m_ovf = 1'b0;
  endtask

  // Check all outputs against the model, then take one clock and advance the
  // model. Called in the low clock phase; returns at the next falling edge.
  task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy);
    int sz;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    sz = m_q.size();
    n_vec++;
    if (out_valid !== (sz != 0)) begin
      n_err++;
      $display("FAIL out_valid: got %0b expected %0b (t=%0t)", out_valid, sz != 0, $time);
    end
    n_vec++;
    if (occupancy !== CW'(sz)) begin
      n_err++;
      $display("FAIL occupancy: got %0d expected %0d (t=%0t)", occupancy, sz, $time);
    end
    n_vec++;
    if (up_ready !== m_rdy) begin
      n_err++;
      $display("FAIL up_ready: got %0b expected %0b (t=%0t)", up_ready, m_rdy, $time);
    end
    n_vec++;
    if (overflow !== m_ovf) begin
      n_err++;
      $display("FAIL overflow: got %0b expected %0b (t=%0t)", overflow, m_ovf, $time);
    end
    if (sz != 0) begin
      n_vec++;
      if (out_data !== m_q[0]) begin
        n_err++;
        $display("FAIL out_data: got %0h expected %0h (t=%0t)", out_data, m_q[0], $time);
      end
    end
    @(posedge clk);
    if (iv && sz == DEPTH) m_ovf = 1'b1;
    if (sz != 0 && ordy) void'(m_q.pop_front());
    if (iv && sz < DEPTH) m_q.push_back(id);
    m_rdy = (m_q.size() <= THR);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && m_q.size() != 0; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if ({up_ready, out_valid, occupancy, overflow} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%0b vld=%0b occ=%0d ovf=%0b expected all 0",
               up_ready, out_valid, occupancy, overflow);
    end
    rst = 1'b0;
    step(1'b0, '0, 1'b0);  // still before first edge: credit low
    n_vec++;
    if (up_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_credit: got %0b expected 1", up_ready);
    end
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
  endtask

  task automatic test_single();
    int vld_cycles = 0;
    step(1'b1, 64'hA5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (out_valid === 1'b1) vld_cycles++;
      step(1'b0, '0, 1'b1);
    end
    n_vec++;
    if (vld_cycles != 1) begin
      n_err++;
      $display("FAIL single_valid_cycles: got %0d expected 1", vld_cycles);
    end
  endtask

  task automatic test_stream();
    int drops = 0;
    for (int i = 0; i < 100; i++) begin
      if (up_ready !== 1'b1) drops++;
      step(1'b1, W'(i), 1'b1);
    end
    drain();
    n_vec++;
    if (drops != 0) begin
      n_err++;
      $display("FAIL stream_credit_drops: got %0d expected 0", drops);
    end
  endtask

  task automatic test_credit();
    logic [N-1:0] sr = '0;
    int launched = 0;
    int arrived = 0;
    int max_occ = 0;
    logic iv;
    for (int c = 0; c < 24; c++) begin
      logic launch;
      launch = (up_ready === 1'b1) && (launched < 40);
      if (launch) launched++;
      iv = sr[N-1];
      sr = {sr[N-2:0], launch};
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      step(iv, iv ? W'(64'hC000 + arrived) : '0, 1'b0);
      if (iv) arrived++;
    end
    n_vec++;
    if (max_occ > DEPTH || max_occ < THR + 1) begin
      n_err++;
      $display("FAIL credit_max_occupancy: got %0d expected %0d..%0d", max_occ, THR + 1, DEPTH);
    end
    n_vec++;
    if (launched != DEPTH) begin
      n_err++;
      $display("FAIL credit_launch_count: got %0d expected %0d", launched, DEPTH);
    end
    drain();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) step(1'b1, W'(64'hF00 + i), 1'b0);
    step(1'b1, 64'hDEAD, 1'b1);  // arrives at full: dropped, head still pops
    n_vec++;
    if (overflow !== 1'b1 || occupancy !== CW'(DEPTH - 1)) begin
      n_err++;
      $display("FAIL overflow_at_full: got ovf=%0b occ=%0d expected ovf=1 occ=%0d",
               overflow, occupancy, DEPTH - 1);
    end
    drain();
    step(1'b0, '0, 1'b1);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) step(1'b1, W'(64'h500 + i), 1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if (occupancy !== '0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_immediate: got occ=%0d vld=%0b ovf=%0b expected 0 0 0",
               occupancy, out_valid, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, '0, 1'b0);
    step(1'b1, 64'h3C, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 64'h3C) begin
      n_err++;
      $display("FAIL mid_reset_first_beat: got vld=%0b data=%0h expected 1 3c", out_valid, out_data);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic iv, ordy;
      iv   = ($urandom_range(99) < 60);
      ordy = ($urandom_range(99) < 50);
      step(iv, {$urandom, $urandom}, ordy);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_credit();
    test_overflow();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
